// File: rtl/joycon_dev_responder_if.sv
// Signal bundle between a Joycon host (master) and the device-side responder
// (slave): the two serial lines, the controller inputs sampled for poll replies,
// the link status outputs and a view of the responder's internal state machines.
//
// Transfer contract: there is no valid/ready pair on this link. A request is
// accepted when its checksum byte's stop bit is sampled; the device answers by
// itself after the response gap and cannot be stalled. poll_strobe and frame_err
// are single-cycle pulses with no acknowledge. connected is a level that stays
// high until reset.
interface joycon_dev_responder_if;
  logic        uart_rx;
  logic        uart_tx;
  logic [15:0] key_state;
  logic [7:0]  stick_x;
  logic [7:0]  stick_y;
  logic        connected;
  logic        poll_strobe;
  logic        frame_err;
  logic [1:0]  rx_state_dbg;
  logic [1:0]  parse_state_dbg;
  logic [1:0]  tx_state_dbg;

  modport slave (
    input  uart_rx, key_state, stick_x, stick_y,
    output uart_tx, connected, poll_strobe, frame_err,
    output rx_state_dbg, parse_state_dbg, tx_state_dbg
  );

  modport master (
    output uart_rx, key_state, stick_x, stick_y,
    input  uart_tx, connected, poll_strobe, frame_err,
    input  rx_state_dbg, parse_state_dbg, tx_state_dbg
  );
endinterface

// File: rtl/joycon_dev_responder.sv
// Device end of the Joycon rail UART link. Receives 3-byte host requests
// (A5, CMD, A5^CMD), answers handshake (01) and poll (30) with fixed-format
// replies after a fixed idle gap, and reports link status and dropped requests.
module joycon_dev_responder #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int BAUD_HZ       = 1_000_000,
  parameter int RESP_GAP_BITS = 4,
  parameter int TIMEOUT_BITS  = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  joycon_dev_responder_if.slave bus
);
  localparam int BIT_CYC = CLK_FREQ_HZ / BAUD_HZ;
  localparam int GAP_CYC = RESP_GAP_BITS * BIT_CYC;
  localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
  localparam int CW      = $clog2(GAP_CYC + TO_CYC + BIT_CYC) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {PS_SYNC, PS_CMD, PS_CHK} ps_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_GAP, TX_SEND} tx_state_t;

  logic rx_s1, rx_s2, rx_d;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, byte_ok, byte_bad;

  ps_state_t     ps_state;
  logic [7:0]    ps_cmd;
  logic [CW-1:0] to_cnt;
  logic          timeout, req_hs, req_poll, parse_err;
  logic          frame_err_q;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [2:0]    tx_byte, last_byte;
  logic          tx_is_poll, tx_busy;
  logic [15:0]   snap_keys;
  logic [7:0]    snap_x, snap_y, cur_byte;
  logic          uart_tx_q, connected_q, poll_strobe_q;

  assign rx_tick  = (rx_cnt == BIT_LAST);
  assign byte_ok  = (rx_state == RX_STOP) && rx_tick && rx_s2;
  assign byte_bad = (rx_state == RX_STOP) && rx_tick && !rx_s2;
  assign timeout  = (ps_state != PS_SYNC) && (rx_state == RX_IDLE) && (to_cnt == TO_LAST);
  assign tx_busy  = (tx_state != TX_IDLE);

  assign bus.uart_tx         = uart_tx_q;
  assign bus.connected       = connected_q;
  assign bus.poll_strobe     = poll_strobe_q;
  assign bus.frame_err       = frame_err_q;
  assign bus.rx_state_dbg    = rx_state;
  assign bus.parse_state_dbg = ps_state;
  assign bus.tx_state_dbg    = tx_state;

  // Two-flop synchronizer on uart_rx plus one delay stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= bus.uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Byte receiver: start re-checked at mid-bit, then one sample per bit time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_d && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Decide the fate of a completed request in the cycle its checksum stop bit is sampled
  always_comb begin
    req_hs    = 1'b0;
    req_poll  = 1'b0;
    parse_err = 1'b0;
    if (byte_ok && (ps_state == PS_CHK)) begin
      if (rx_shift != (8'hA5 ^ ps_cmd))           parse_err = 1'b1;
      else if (ps_cmd == 8'h01 && !tx_busy)       req_hs    = 1'b1;
      else if (ps_cmd == 8'h30 && !tx_busy && connected_q) req_poll = 1'b1;
      else                                        parse_err = 1'b1;
    end
  end

  // Frame parser with inter-byte timeout; drives the frame_err pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_state    <= PS_SYNC;
      ps_cmd      <= '0;
      to_cnt      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= byte_bad | parse_err | timeout;
      if (byte_ok) begin
        to_cnt <= '0;
        case (ps_state)
          PS_SYNC: if (rx_shift == 8'hA5) ps_state <= PS_CMD;
          PS_CMD: begin
            ps_cmd   <= rx_shift;
            ps_state <= PS_CHK;
          end
          default: ps_state <= PS_SYNC;
        endcase
      end else if (byte_bad || timeout) begin
        to_cnt <= '0;
        if (timeout) ps_state <= PS_SYNC;
      end else if ((ps_state != PS_SYNC) && (rx_state == RX_IDLE)) begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

  // Reply byte currently being shifted out, built from the snapshot registers
  always_comb begin
    cur_byte  = 8'h00;
    last_byte = tx_is_poll ? 3'd6 : 3'd3;
    if (tx_is_poll) begin
      case (tx_byte)
        3'd0:    cur_byte = 8'h5A;
        3'd1:    cur_byte = 8'hB0;
        3'd2:    cur_byte = snap_keys[15:8];
        3'd3:    cur_byte = snap_keys[7:0];
        3'd4:    cur_byte = snap_x;
        3'd5:    cur_byte = snap_y;
        default: cur_byte = 8'h5A ^ 8'hB0 ^ snap_keys[15:8] ^ snap_keys[7:0] ^ snap_x ^ snap_y;
      endcase
    end else begin
      case (tx_byte)
        3'd0:    cur_byte = 8'h5A;
        3'd1:    cur_byte = 8'h81;
        3'd2:    cur_byte = 8'h00;
        default: cur_byte = 8'hDB;
      endcase
    end
  end

  // Reply FSM: idle gap, then back-to-back 8N1 bytes; snapshot and status at first start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_byte       <= '0;
      tx_is_poll    <= 1'b0;
      snap_keys     <= '0;
      snap_x        <= '0;
      snap_y        <= '0;
      uart_tx_q     <= 1'b1;
      connected_q   <= 1'b0;
      poll_strobe_q <= 1'b0;
    end else begin
      poll_strobe_q <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (req_hs || req_poll) begin
            tx_state   <= TX_GAP;
            tx_cnt     <= CW'(1);
            tx_is_poll <= req_poll;
          end
        end
        TX_GAP: begin
          if (tx_cnt == GAP_LAST) begin
            tx_state  <= TX_SEND;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_byte   <= '0;
            uart_tx_q <= 1'b0;
            snap_keys <= bus.key_state;
            snap_x    <= bus.stick_x;
            snap_y    <= bus.stick_y;
            if (tx_is_poll) poll_strobe_q <= 1'b1;
            else            connected_q   <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              if (tx_byte == last_byte) begin
                tx_state  <= TX_IDLE;
                uart_tx_q <= 1'b1;
              end else begin
                tx_byte   <= tx_byte + 3'd1;
                tx_bit    <= '0;
                uart_tx_q <= 1'b0;
              end
            end else begin
              tx_bit    <= tx_bit + 4'd1;
              uart_tx_q <= (tx_bit == 4'd8) ? 1'b1 : cur_byte[tx_bit[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule
